// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - MEM-stage 32-bit word access sequenced as two half-word async SRAM cycles
//
// Purpose: a MEM-stage load or store becomes two half-word cycles on a 16-bit async SRAM.
//   The low half is transferred first, then the high half. Each half lasts WAIT_CYCLES clocks.
//   ready is held low so the pipeline stays frozen until the word access completes.
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en             load / store request from the MEM stage (a store wins if both are set)
//   address, write_data      CPU byte address and store data
//   read_data                registered load data
//   ready                    1 = pipeline may advance, 0 = freeze
//   sram_addr                SRAM half-word address
//   sram_dq_out, sram_dq_oe  write data and its tristate enable
//   sram_dq_in               read data from the SRAM
//   sram_ce_n, sram_oe_n     chip enable and output enable, both active low
//   sram_we_n                write enable, active low
//   sram_ub_n, sram_lb_n     byte lane enables, both active low
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  localparam int          WORD_W = SRAM_ADDR_W - 1;
  localparam logic [31:0] BASE   = 32'(BASE_ADDR);
  // The counter holds the clocks remaining in the current half; 0 marks its last clock.
  localparam logic [3:0]  RELOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              is_wr;
  logic [WORD_W-1:0] word;
  logic [15:0]       wdata_hi;
  logic [WORD_W-1:0] req_word;

  // The subtraction wraps, so addresses below BASE_ADDR land at the top of the SRAM.
  assign req_word = WORD_W'((address - BASE) >> 2);

  assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  // The strobes are registered. Each is loaded on the edge that enters the clock it applies to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      word        <= '0;
      wdata_hi    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            state      <= LOW;
            cnt        <= RELOAD;
            is_wr      <= wr_en;
            word       <= req_word;
            wdata_hi   <= write_data[31:16];
            sram_addr  <= {req_word, 1'b0};
            sram_ce_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
            sram_oe_n  <= wr_en;
            sram_dq_oe <= wr_en;
            // WAIT_CYCLES >= 2, so the first clock of a half is never the data-hold clock.
            sram_we_n  <= !wr_en;
            if (wr_en) sram_dq_out <= write_data[15:0];
          end
        end
        LOW: begin
          if (cnt == 4'd0) begin
            state     <= HIGH;
            cnt       <= RELOAD;
            sram_addr <= {word, 1'b1};
            sram_we_n <= !is_wr;
            if (is_wr) sram_dq_out     <= wdata_hi;
            else       read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt - 4'd1;
            // The last clock of a half is the data-hold clock, so we_n rises on entry to it.
            if (cnt == 4'd1) sram_we_n <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          // A request still held here is only honoured after the return to IDLE.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - randomized self-checking bench for sram_mem_controller at two wait-state settings
module tb_sram_mem_controller;

  localparam int BASE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int W = (g == 0) ? 2 : 4;

    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in = '0;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_ADDR_W(18)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // Async SRAM device: writes on the rising edge of we_n, drives data while ce_n and oe_n are low.
    logic [15:0] sram [logic [17:0]];

    function automatic logic [15:0] sram_get(input logic [17:0] a);
      return sram.exists(a) ? sram[a] : 16'h0000;
    endfunction

    always @(posedge sram_we_n) if (sram_ce_n === 1'b0) sram[sram_addr] = sram_dq_out;

    always @(negedge clk)
      sram_dq_in <= (!sram_ce_n && !sram_oe_n) ? sram_get(sram_addr) : 16'($urandom);

    // Reference model: k counts clocks since the request edge (0 = idle, 2W+1 = completion clock).
    int          k = 0;
    bit          m_wr = 1'b0;
    logic [16:0] m_word = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_rd = '0;
    logic [31:0] ref_mem [int];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        k    <= 0;
        m_rd <= '0;
      end else if (k == 0) begin
        if (rd_en || wr_en) begin
          k      <= 1;
          m_wr   <= wr_en;
          m_word <= 17'((address - BASE) >> 2);
          m_wd   <= write_data;
          if (wr_en) ref_mem[int'(17'((address - BASE) >> 2))] = write_data;
        end
      end else if (k == 2 * W + 1) begin
        k <= 0;
      end else begin
        k <= k + 1;
        if (k + 1 == 2 * W + 1 && !m_wr)
          m_rd <= ref_mem.exists(int'(m_word)) ? ref_mem[int'(m_word)] : 32'h0;
      end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
      string tag;
      int    p;
      int    half;
      bit    last;
      if (chk_en) begin
        tag = $sformatf("W%0d", W);
        if (k == 0 || k == 2 * W + 1) begin
          chk({tag, " idle strobes"},
              {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, 6'b111110);
          chk({tag, " idle ready"}, ready, (k != 0) || !(rd_en || wr_en));
          chk({tag, " read_data"}, read_data, m_rd);
        end else begin
          p    = k - 1;
          half = p / W;
          last = (p % W) == W - 1;
          chk({tag, " busy strobes"},
              {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
              {1'b0, m_wr, !(m_wr && !last), 1'b0, 1'b0, m_wr});
          chk({tag, " sram_addr"}, sram_addr, {m_word, half[0]});
          if (m_wr) chk({tag, " dq_out"}, sram_dq_out, (half == 1) ? m_wd[31:16] : m_wd[15:0]);
          chk({tag, " busy ready"}, ready, 0);
        end
      end
    end

    // One request clock, then wait for ready; counts ready-low and we_n-low clocks after the request edge.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd_at_done, output int low_clks, output int we_clks);
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; address = a; write_data = d;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      low_clks = 0;
      we_clks  = 0;
      for (int guard = 0; guard < 64; guard++) begin
        @(negedge clk);
        if (ready) break;
        low_clks++;
        if (!sram_we_n) we_clks++;
      end
      if (!ready) chk($sformatf("W%0d ready timeout", W), ready, 1);
      rd_at_done = read_data;
    endtask

    initial begin
      logic [31:0] rv;
      logic [31:0] a;
      int          lc, wc, n, kind;
      bit          prev;
      string       tag;
      tag = $sformatf("W%0d", W);
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      chk({tag, " reset ready"}, ready, 1);
      chk({tag, " reset read_data"}, read_data, 0);

      do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, rv, lc, wc);
      chk({tag, " store ready-low clks"}, lc, 2 * W);
      chk({tag, " store we_n-low clks"}, wc, 2 * (W - 1));
      chk({tag, " sram[2]"}, sram_get(18'd2), 16'hBEEF);
      chk({tag, " sram[3]"}, sram_get(18'd3), 16'hDEAD);

      do_access(1'b1, 1'b0, 32'd1028, 32'h0, rv, lc, wc);
      chk({tag, " load data"}, rv, 32'hDEADBEEF);
      chk({tag, " load ready-low clks"}, lc, 2 * W);
      chk({tag, " load we_n-low clks"}, wc, 0);

      n    = 0;
      prev = 1'b1;
      for (int i = 0; i < 12 + 2 * W + 2; i++) begin
        @(posedge clk); #1;
        rd_en   = (i < 12);
        address = 32'd1028;
        @(negedge clk);
        if (prev && !sram_ce_n) n++;
        prev = sram_ce_n;
      end
      chk({tag, " held-load access count"}, n, (12 + 2 * W + 1) / (2 * W + 2));

      do_access(1'b1, 1'b1, 32'd1024, 32'h00010002, rv, lc, wc);
      chk({tag, " both-enables read_data kept"}, rv, 32'hDEADBEEF);
      chk({tag, " both-enables we_n-low clks"}, wc, 2 * (W - 1));
      chk({tag, " both-enables sram[0]"}, sram_get(18'd0), 16'h0002);
      do_access(1'b1, 1'b0, 32'd1024, 32'h0, rv, lc, wc);
      chk({tag, " reload word 0"}, rv, 32'h00010002);

      do_access(1'b0, 1'b1, 32'(BASE - 4), 32'hCAFE1234, rv, lc, wc);
      chk({tag, " wrap low half"}, sram_get(18'h3FFFE), 16'h1234);
      chk({tag, " wrap high half"}, sram_get(18'h3FFFF), 16'hCAFE);
      do_access(1'b1, 1'b0, 32'(BASE - 4), 32'h0, rv, lc, wc);
      chk({tag, " wrap load"}, rv, 32'hCAFE1234);

      for (int i = 0; i < 40; i++) begin
        kind = int'($urandom_range(0, 2));
        a    = 32'(BASE + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3)));
        do_access(kind != 1, kind != 0, a, $urandom, rv, lc, wc);
        chk({tag, " random ready-low clks"}, lc, 2 * W);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      do_access(1'b0, 1'b1, 32'd1028, 32'h13579BDF, rv, lc, wc);
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, rv, lc, wc);
      chk({tag, " pre-reset load"}, rv, 32'h13579BDF);
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'(BASE + 400); write_data = 32'h5A5AA5A5;
      @(posedge clk); #1;
      wr_en = 1'b0;
      repeat (W) @(posedge clk);
      #1;
      chk({tag, " we_n in first HIGH clk"}, sram_we_n, 0);
      rst_n = 1'b0;
      #1;
      chk({tag, " abort strobes"}, {sram_we_n, sram_ce_n, sram_dq_oe, ready}, 4'b1101);
      chk({tag, " abort read_data"}, read_data, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, rv, lc, wc);
      chk({tag, " post-reset load"}, rv, 32'h13579BDF);
      repeat (2) @(posedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1])) chk("bench timeout", {done[0], done[1]}, 2'b11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
